multiboot_request_ctrl: RTL

- Upstream front-end for the multiboot/ICAP reboot block: turns a guarded byte-write command sequence from the NextREG/CPU side into one clean reboot request.
- Validates an unlock/commit sequence and range-checks the target core ID.
- Computes the SPI flash start address for status readback.
- Asserts a quiesce window so SDRAM and video can settle, then drives the reboot request and core ID into the multiboot block.

---
 rtl/multiboot_request_ctrl_if.sv | 21 ++
 rtl/multiboot_request_ctrl.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/multiboot_request_ctrl_if.sv
// Command byte-write port and reboot-request outputs of the multiboot request front-end.
interface multiboot_request_ctrl_if;
   logic        cmd_wr_i;
   logic [7:0]  cmd_data_i;
   logic        quiesce_o;
   logic        reboot_core_x_o;
   logic [4:0]  reboot_core_id_o;
   logic [23:0] spi_addr_o;
   logic        busy_o;
   logic        err_o;

   modport master (
      output cmd_wr_i, cmd_data_i,
      input  quiesce_o, reboot_core_x_o, reboot_core_id_o, spi_addr_o, busy_o, err_o
   );

   modport slave (
      input  cmd_wr_i, cmd_data_i,
      output quiesce_o, reboot_core_x_o, reboot_core_id_o, spi_addr_o, busy_o, err_o
   );
endinterface

// File: rtl/multiboot_request_ctrl.sv
// Guarded unlock/id/commit byte sequence -> one reboot request after a quiesce window.
// Latency: request rises HOLDOFF_CYCLES+2 cycles after the commit write; no backpressure, writes outside the sequence are dropped.
module multiboot_request_ctrl #(
   parameter logic [7:0] KEY0           = 8'h5A,
   parameter logic [7:0] KEY1           = 8'hA5,
   parameter logic [7:0] COMMIT         = 8'hC3,
   parameter int         MAX_CORE_ID    = 20,
   parameter int         SEQ_TIMEOUT    = 65535,
   parameter int         HOLDOFF_CYCLES = 1024,
   parameter int         PULSE_CYCLES   = 8
) (
   input  logic                    clk_icap,
   input  logic                    reset_n_i,
   multiboot_request_ctrl_if.slave bus
);

   // The multiboot block edge-detects the request, so it needs at least two cycles.
   localparam int PULSE_EFF = (PULSE_CYCLES < 2) ? 2 : PULSE_CYCLES;
   localparam int HOLD_EFF  = (HOLDOFF_CYCLES < 1) ? 1 : HOLDOFF_CYCLES;
   localparam int CNT_MAX   = (PULSE_EFF > HOLD_EFF) ? PULSE_EFF : HOLD_EFF;
   localparam int CW        = $clog2(CNT_MAX + 1);
   localparam int TW        = $clog2(SEQ_TIMEOUT + 1);
   localparam logic [4:0]  MAX_ID       = 5'(MAX_CORE_ID);
   localparam logic [23:0] DEFAULT_ADDR = 24'h0B0000;

   typedef enum logic [2:0] {
      S_IDLE, S_UNLK1, S_UNLK2, S_ARMED, S_CALC, S_QUIESCE, S_FIRE
   } state_t;

   state_t      state;
   logic [4:0]  id_q;
   logic [TW-1:0] to_cnt;
   logic [CW-1:0] cnt;
   logic        quiesce_q;
   logic        reboot_q;
   logic [4:0]  core_id_q;
   logic [23:0] addr_q;
   logic        err_q;

   // Page arithmetic is done in 13 bits so the product is not truncated before the subtract.
   function automatic logic [11:0] page_of(input logic [4:0] id);
      logic [12:0] prod;
      logic [12:0] diff;
      prod = 13'h0C4 * {8'd0, id};
      diff = prod - 13'h014;
      return (id == 5'd0) ? 12'h0B0 : diff[11:0];
   endfunction

   always_ff @(posedge clk_icap or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state     <= S_IDLE;
         id_q      <= '0;
         to_cnt    <= '0;
         cnt       <= '0;
         quiesce_q <= 1'b0;
         reboot_q  <= 1'b0;
         core_id_q <= '0;
         addr_q    <= DEFAULT_ADDR;
         err_q     <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.cmd_wr_i && bus.cmd_data_i == KEY0) begin
                  state  <= S_UNLK1;
                  err_q  <= 1'b0;
                  to_cnt <= '0;
               end
            end
            S_UNLK1, S_UNLK2, S_ARMED: begin
               if (bus.cmd_wr_i) begin
                  to_cnt <= '0;
                  if (state == S_UNLK1) begin
                     if (bus.cmd_data_i == KEY1) begin
                        state <= S_UNLK2;
                     end else begin
                        state <= S_IDLE;
                        err_q <= 1'b1;
                     end
                  end else if (state == S_UNLK2) begin
                     if (bus.cmd_data_i[7:5] == 3'b000) begin
                        id_q  <= bus.cmd_data_i[4:0];
                        state <= S_ARMED;
                     end else begin
                        state <= S_IDLE;
                        err_q <= 1'b1;
                     end
                  end else begin
                     if (bus.cmd_data_i == COMMIT && id_q <= MAX_ID) begin
                        state <= S_CALC;
                     end else begin
                        state <= S_IDLE;
                        err_q <= 1'b1;
                     end
                  end
               end else if (to_cnt == TW'(SEQ_TIMEOUT - 1)) begin
                  state  <= S_IDLE;
                  err_q  <= 1'b1;
                  to_cnt <= '0;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            S_CALC: begin
               addr_q    <= {page_of(id_q), 12'h000};
               core_id_q <= id_q;
               cnt       <= CW'(HOLD_EFF - 1);
               quiesce_q <= 1'b1;
               state     <= S_QUIESCE;
            end
            S_QUIESCE: begin
               if (cnt == '0) begin
                  state    <= S_FIRE;
                  reboot_q <= 1'b1;
                  cnt      <= CW'(PULSE_EFF - 1);
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            S_FIRE: begin
               if (cnt == '0) begin
                  state     <= S_IDLE;
                  reboot_q  <= 1'b0;
                  quiesce_q <= 1'b0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.quiesce_o        = quiesce_q;
   assign bus.reboot_core_x_o  = reboot_q;
   assign bus.reboot_core_id_o = core_id_q;
   assign bus.spi_addr_o       = addr_q;
   assign bus.busy_o           = (state != S_IDLE);
   assign bus.err_o            = err_q;

endmodule
